// File: rtl/switch_event_master.sv
`default_nettype none
// ============================================================================
// Module   : switch_event_master
// Brief    : Synchronise, debounce and queue switch-vector changes for the
//            master side of the LED link (FWFT FIFO, valid/ready output).
// Revision : 1.0 - initial release
// ============================================================================
module switch_event_master #(
    parameter int W               = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     inSwitch,
    input  logic             ready,
    output logic             outValid,
    output logic [W-1:0]     dataOut,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_DB_W-1:0]  c_DB_MAX   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   c_DROP_ONE = CNT_W'(1);

    logic [W-1:0]       r_sync1;
    logic [W-1:0]       r_sync2;
    logic [W-1:0]       r_cand;
    logic [W-1:0]       r_stable;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic               r_push;
    logic [W-1:0]       r_push_data;

    logic [W-1:0]       r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_count;

    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_drop;

    // Synchroniser and whole-vector debounce; a commit raises a one-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cand      <= '0;
            r_stable    <= '0;
            r_db_cnt    <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_sync1 <= inSwitch;
            r_sync2 <= r_sync1;
            r_push  <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand   <= r_sync2;
                r_db_cnt <= '0;
            end else if (r_db_cnt < c_DB_MAX) begin
                r_db_cnt <= r_db_cnt + c_DB_ONE;
            end else if (r_cand != r_stable) begin
                r_stable    <= r_cand;
                r_push      <= 1'b1;
                r_push_data <= r_cand;
            end
        end
    end

    assign outValid = (r_count != '0);
    assign dataOut  = outValid ? r_mem[r_rd_ptr] : '0;
    assign w_pop    = outValid & ready;
    assign w_full   = (r_count == c_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign w_wr     = r_push & (~w_full | w_pop);
    assign w_drop   = r_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + c_DROP_ONE;
                end
            end
        end
    end

    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_switch_event_master.sv
`default_nettype none
// Bench for switch_event_master: table vectors, directed corner sequences and
// randomized traffic checked against a sample-window reference model.
module tb_switch_event_master;

    localparam int W     = 2;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_sw;
    logic          ready;
    logic          out_valid;
    logic [W-1:0]  data_out;
    logic          overflow;
    logic [CW-1:0] drop_count;

    switch_event_master #(
        .W(W), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .inSwitch(in_sw), .ready(ready),
        .outValid(out_valid), .dataOut(data_out),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a change is committed once D+1 consecutive samples seen
    // through the two-flop synchroniser agree and differ from the last commit;
    // the commit enters the queue on the following edge.
    logic [W-1:0] hist [D+3];
    logic [W-1:0] mq [$];
    logic [W-1:0] m_stable;
    logic         m_pend;
    logic [W-1:0] m_pend_data;
    logic         m_ovf;
    int           m_drops;

    task automatic model_edge();
        bit all_eq;
        if (rst) begin
            for (int i = 0; i < D + 3; i++) hist[i] = '0;
            mq.delete();
            m_stable = '0; m_pend = 1'b0; m_pend_data = '0;
            m_ovf = 1'b0; m_drops = 0;
        end else begin
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back(m_pend_data);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < SAT) m_drops++;
                end
            end
            m_pend = 1'b0;
            for (int i = D + 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = in_sw;
            all_eq = 1'b1;
            for (int i = 3; i <= D + 2; i++) if (hist[i] != hist[2]) all_eq = 1'b0;
            if (all_eq && hist[2] != m_stable) begin
                m_stable = hist[2]; m_pend = 1'b1; m_pend_data = hist[2];
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic          ev;
        logic [W-1:0]  ed;
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : '0;
        n_vec++;
        if (out_valid !== ev || data_out !== ed || overflow !== m_ovf ||
            drop_count !== CW'(m_drops)) begin
            n_miss++;
            $display("FAIL %s: got valid=%0b data=%0h ovf=%0b drops=%0d, want valid=%0b data=%0h ovf=%0b drops=%0d",
                     tag, out_valid, data_out, overflow, drop_count, ev, ed, m_ovf, m_drops);
        end
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] s, input logic rd, input string tag);
        rst = r; in_sw = s; ready = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic hold(input logic [W-1:0] s, input logic rd, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, s, rd, tag);
    endtask

    typedef struct {
        logic         r;
        logic [W-1:0] sw;
        logic         rdy;
        logic         ev;
        logic [W-1:0] ed;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int  seen;
        int  first;
        bit  any_valid;
        logic [W-1:0] exp_seq [3];
        logic [W-1:0] exp4 [4];
        logic [W-1:0] cur;

        rst = 1'b1; in_sw = '0; ready = 1'b0;

        // Test 1: reset, then 00->01 just before edge 0; valid only after edge 7.
        tbl[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
        for (int k = 0; k <= 8; k++)
            tbl[k+2] = '{1'b0, 2'b01, 1'b1, (k == 7), (k == 7) ? 2'b01 : 2'b00};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].sw, tbl[i].rdy, "t1_model");
            expect_val($sformatf("t1_valid_row%0d", i), int'(out_valid), int'(tbl[i].ev));
            expect_val($sformatf("t1_data_row%0d", i), int'(data_out), int'(tbl[i].ed));
        end
        expect_val("t1_overflow", int'(overflow), 0);

        // Test 2: a 3-cycle glitch yields nothing; a 10-cycle hold yields one event.
        step(1'b1, 2'b00, 1'b1, "t2_rst");
        any_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin step(1'b0, 2'b10, 1'b1, "t2_glitch"); any_valid |= out_valid; end
        for (int i = 0; i < 12; i++) begin step(1'b0, 2'b00, 1'b1, "t2_quiet"); any_valid |= out_valid; end
        expect_val("t2_glitch_no_valid", int'(any_valid), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b10, 1'b1, "t2_hold");
            if (out_valid) begin
                seen++;
                expect_val("t2_event_data", int'(data_out), 2);
            end
        end
        expect_val("t2_event_count", seen, 1);

        // Test 3: backpressure fills the FIFO, a fifth change is dropped.
        hold(2'b01, 1'b0, 8, "t3_fill");
        hold(2'b11, 1'b0, 8, "t3_fill");
        hold(2'b10, 1'b0, 8, "t3_fill");
        hold(2'b00, 1'b0, 8, "t3_fill");
        expect_val("t3_full_valid", int'(out_valid), 1);
        expect_val("t3_full_head", int'(data_out), 1);
        expect_val("t3_no_ovf_yet", int'(overflow), 0);
        hold(2'b01, 1'b0, 8, "t3_drop");
        expect_val("t3_overflow", int'(overflow), 1);
        expect_val("t3_drop_count", int'(drop_count), 1);
        expect_val("t3_head_held", int'(data_out), 1);
        exp_seq[0] = 2'b11; exp_seq[1] = 2'b10; exp_seq[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 1'b1, "t3_drain");
            expect_val($sformatf("t3_order%0d", i), int'(data_out), int'(exp_seq[i]));
        end
        step(1'b0, 2'b01, 1'b1, "t3_drain");
        expect_val("t3_empty", int'(out_valid), 0);

        // Test 4: full FIFO, push and pop land on the same edge.
        hold(2'b00, 1'b0, 8, "t4_fill");
        hold(2'b10, 1'b0, 8, "t4_fill");
        hold(2'b11, 1'b0, 8, "t4_fill");
        hold(2'b00, 1'b0, 8, "t4_fill");
        hold(2'b01, 1'b0, 7, "t4_pre");
        expect_val("t4_full_head", int'(data_out), 0);
        expect_val("t4_full_valid", int'(out_valid), 1);
        step(1'b0, 2'b01, 1'b1, "t4_pushpop");
        expect_val("t4_no_drop", int'(drop_count), 1);
        exp4[0] = 2'b10; exp4[1] = 2'b11; exp4[2] = 2'b00; exp4[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            expect_val($sformatf("t4_order%0d", i), int'(data_out), int'(exp4[i]));
            step(1'b0, 2'b01, 1'b1, "t4_drain");
        end
        expect_val("t4_empty", int'(out_valid), 0);
        expect_val("t4_drops_kept", int'(drop_count), 1);

        // Test 5: reset with events queued and switches at 11.
        hold(2'b10, 1'b0, 8, "t5_fill");
        hold(2'b11, 1'b0, 8, "t5_fill");
        expect_val("t5_queued", int'(out_valid), 1);
        step(1'b1, 2'b11, 1'b0, "t5_rst");
        expect_val("t5_rst_valid", int'(out_valid), 0);
        expect_val("t5_rst_data", int'(data_out), 0);
        expect_val("t5_rst_drops", int'(drop_count), 0);
        first = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 2'b11, 1'b1, "t5_redetect");
            if (out_valid && first < 0) begin
                first = k;
                expect_val("t5_redetect_data", int'(data_out), 3);
            end
        end
        expect_val("t5_redetect_edge", first, D + 3);

        // Test 6: 4 fills plus 300 drops saturate the counter.
        step(1'b1, 2'b00, 1'b0, "t6_rst");
        cur = 2'b01;
        for (int e = 0; e < 304; e++) begin
            hold(cur, 1'b0, 6, "t6_drops");
            cur = (cur == 2'b01) ? 2'b10 : 2'b01;
        end
        hold(cur, 1'b0, 2, "t6_settle");
        expect_val("t6_drop_sat", int'(drop_count), SAT);
        expect_val("t6_overflow", int'(overflow), 1);

        // Randomized traffic against the reference model.
        step(1'b1, 2'b00, 1'b0, "rnd_rst");
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) cur = W'($urandom_range(0, (1 << W) - 1));
            step(($urandom_range(0, 299) == 0), cur, ($urandom_range(0, 3) != 0) ^ (i[9] & i[8]),
                 "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
